// File: rtl/mantle_pack_pkg.sv
// Shared types and sizing for the nibble-to-word packer.
package mantle_pack_pkg;

  localparam int PACK_WIDTH = 16;
  localparam int PACK_LANE  = 4;
  localparam int LANES      = PACK_WIDTH / PACK_LANE;
  localparam int CNT_W      = $clog2(LANES);

  typedef struct packed {
    logic                  partial;
    logic [PACK_WIDTH-1:0] data;
  } pack_word_t;

endpackage

// File: rtl/mantle_word_fifo.sv
// Register-based circular FIFO; pointers carry one extra wrap bit for full/empty.
module mantle_word_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // When full, a push is accepted only alongside a pop: it lands in the slot being vacated.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/mantle_nibble_word_packer.sv
// Packs LANE-bit beats into WIDTH-bit words (lane 0 = LSBs); flush closes a partial word.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
module mantle_nibble_word_packer
  import mantle_pack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANE-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_partial,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [CNT_W-1:0] lane_cnt_q, lane_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             flush_pend_q, flush_pend_d;
  logic             accept, last_lane, push, pop;
  logic             fifo_full, fifo_empty;
  pack_word_t       push_word, head_word;

  assign last_lane = (lane_cnt_q == CNT_W'(LANES - 1));
  // Only the completing beat needs FIFO room, so earlier lanes keep flowing while full.
  assign in_ready  = !(last_lane && fifo_full) && !flush_pend_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    lane_cnt_d   = lane_cnt_q;
    shift_d      = shift_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_word    = '0;
    if (flush_pend_q) begin
      if (!fifo_full) begin
        push              = 1'b1;
        push_word.partial = 1'b1;
        push_word.data    = shift_q;
        flush_pend_d      = 1'b0;
        lane_cnt_d        = '0;
        shift_d           = '0;
      end
    end else if (accept) begin
      if (last_lane) begin
        // A completing beat wins over a simultaneous flush: the word is already full.
        push           = 1'b1;
        push_word.data = {in_data, shift_q[WIDTH-LANE-1:0]};
        lane_cnt_d     = '0;
        shift_d        = '0;
      end else begin
        for (int k = 0; k < LANES; k++) begin
          if (lane_cnt_q == CNT_W'(k)) shift_d[k*LANE +: LANE] = in_data;
        end
        lane_cnt_d = lane_cnt_q + CNT_W'(1);
        if (flush) flush_pend_d = 1'b1;
      end
    end else if (flush && (lane_cnt_q != '0)) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q   <= '0;
      shift_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      shift_q      <= shift_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  mantle_word_fifo #(
    .T     (pack_word_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_data    = head_word.data;
  assign out_partial = head_word.partial;

endmodule
